// File: rtl/move_player.sv
// move_player: drains a 2-bit move stack into an internal buffer, then replays
// the buffered path in forward order (oldest move first) over a valid/ready
// handshake. The buffer and count survive a replay so the path can be replayed
// again without re-draining.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous reset, active low
//   load       start draining the path stack (IDLE or READY)
//   run        start replaying the buffered path (READY only)
//   stk_empty  path stack empty flag
//   stk_data   top-of-stack move, valid while stk_empty=0
//   stk_pop    pop strobe to the path stack (combinational)
//   move       replayed move, valid while move_valid=1
//   move_valid replayed move is being presented
//   move_ready consumer accepts the presented move
//   count      number of moves held in the buffer, 0..DEPTH
//   busy       high while draining or replaying
//   done       one-cycle pulse when a replay completes
//   ovf        sticky: stack still held moves when the buffer filled up
module move_player #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          run,
  input  logic          stk_empty,
  input  logic [1:0]    stk_data,
  output logic          stk_pop,
  output logic [1:0]    move,
  output logic          move_valid,
  input  logic          move_ready,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READY,
    PLAY,
    FIN
  } state_t;

  state_t        state_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [1:0]    move_q;
  logic          ovf_q;

  // Path buffer; contents are don't-care after reset, so it has no reset.
  logic [1:0]    buf_q [DEPTH];

  logic          full;
  logic          pop;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] rd_prev;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop      = (state_q == DRAIN) & ~stk_empty & ~full;
  // With count=DEPTH the low AW bits wrap to 0, so this still yields DEPTH-1.
  assign last_idx = count_q[AW-1:0] - AW'(1);
  assign rd_prev  = rd_ptr_q - AW'(1);

  // The first pop is the newest move, so buf[0] is the end of the path and
  // replay walks the buffer downward from count-1.
  always_ff @(posedge clk) begin
    if (pop) begin
      buf_q[count_q[AW-1:0]] <= stk_data;
    end
  end

  // move is fetched one edge ahead from the buffer so it is a plain register
  // while presented and naturally holds under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      move_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= DRAIN;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        DRAIN: begin
          if (pop) begin
            count_q <= count_q + (AW+1)'(1);
          end else if (stk_empty) begin
            state_q <= READY;
          end else begin
            ovf_q   <= 1'b1;
            state_q <= READY;
          end
        end
        READY: begin
          if (load) begin
            state_q <= DRAIN;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end else if (run) begin
            if (count_q == '0) begin
              state_q <= FIN;
            end else begin
              state_q  <= PLAY;
              rd_ptr_q <= last_idx;
              move_q   <= buf_q[last_idx];
            end
          end
        end
        PLAY: begin
          if (move_ready) begin
            if (rd_ptr_q == '0) begin
              state_q <= FIN;
            end else begin
              rd_ptr_q <= rd_prev;
              move_q   <= buf_q[rd_prev];
            end
          end
        end
        FIN: begin
          state_q <= READY;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stk_pop    = pop;
  assign move       = move_q;
  assign move_valid = (state_q == PLAY);
  assign count      = count_q;
  assign busy       = (state_q == DRAIN) | (state_q == PLAY);
  assign done       = (state_q == FIN);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_move_player.sv
module tb_move_player;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        run = 1'b0;
  logic        stk_empty = 1'b1;
  logic [1:0]  stk_data = 2'b00;
  logic        move_ready = 1'b0;
  logic        stk_pop;
  logic [1:0]  move;
  logic        move_valid;
  logic [AW:0] count;
  logic        busy;
  logic        done;
  logic        ovf;

  always #5 clk = ~clk;

  move_player #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load(load), .run(run),
    .stk_empty(stk_empty), .stk_data(stk_data), .stk_pop(stk_pop),
    .move(move), .move_valid(move_valid), .move_ready(move_ready),
    .count(count), .busy(busy), .done(done), .ovf(ovf)
  );

  // Behavioural model: the buffer is a list of captured moves, a replay is a
  // list of moves still owed to the consumer.
  typedef enum int {M_IDLE, M_DRAIN, M_READY, M_PLAY, M_FIN} mode_t;
  mode_t      m_mode = M_IDLE;
  logic [1:0] m_buf[$];
  logic [1:0] m_pend[$];
  bit         m_ovf = 1'b0;

  // Environment: stack (top = last element) and observation logs.
  logic [1:0] stk[$];
  logic [1:0] popped[$];
  logic [1:0] played[$];
  logic [1:0] orig[$];
  int done_cnt = 0;
  int mv_cycles = 0;
  bit rnd_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_buf.delete();
    m_pend.delete();
    m_ovf = 1'b0;
  endtask

  // One clock cycle: entered at a falling edge with inputs applied; compares
  // DUT against the model, advances the model, returns at the next falling edge.
  task automatic cycle();
    bit exp_pop;
    bit dpop;
    stk_empty = (stk.size() == 0);
    stk_data  = stk_empty ? 2'b00 : stk[$];
    #1;
    exp_pop = rst && (m_mode == M_DRAIN) && !stk_empty && (m_buf.size() < DEPTH);
    chk("stk_pop", 32'(stk_pop), 32'(exp_pop));
    chk("move_valid", 32'(move_valid), 32'(m_mode == M_PLAY));
    if (m_mode == M_PLAY) chk("move", 32'(move), 32'(m_pend[0]));
    chk("count", 32'(count), 32'(m_buf.size()));
    chk("busy", 32'(busy), 32'(m_mode == M_DRAIN || m_mode == M_PLAY));
    chk("done", 32'(done), 32'(m_mode == M_FIN));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("pop_and_valid", 32'(stk_pop & move_valid), 32'(0));
    if (stk_pop) popped.push_back(stk_data);
    if (move_valid && move_ready) played.push_back(move);
    if (done) done_cnt++;
    if (move_valid) mv_cycles++;
    dpop = stk_pop;

    if (!rst) begin
      model_reset();
    end else begin
      case (m_mode)
        M_IDLE: if (load) begin
          m_mode = M_DRAIN; m_buf.delete(); m_ovf = 1'b0;
        end
        M_DRAIN: begin
          if (exp_pop) m_buf.push_back(stk[$]);
          else begin
            if (!stk_empty) m_ovf = 1'b1;
            m_mode = M_READY;
          end
        end
        M_READY: begin
          if (load) begin
            m_mode = M_DRAIN; m_buf.delete(); m_ovf = 1'b0;
          end else if (run) begin
            m_pend.delete();
            foreach (m_buf[i]) m_pend.push_front(m_buf[i]);
            m_mode = (m_buf.size() == 0) ? M_FIN : M_PLAY;
          end
        end
        M_PLAY: if (move_ready) begin
          void'(m_pend.pop_front());
          if (m_pend.size() == 0) m_mode = M_FIN;
        end
        M_FIN: m_mode = M_READY;
        default: m_mode = M_IDLE;
      endcase
    end

    @(posedge clk);
    if (dpop && stk.size() > 0) void'(stk.pop_back());
    @(negedge clk);
  endtask

  task automatic wait_mode(input mode_t target, input int max, input string name);
    int n = 0;
    while (m_mode != target && n < max) begin
      if (rnd_ready) move_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    if (m_mode != target) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout after %0d cycles, got mode %0d expected %0d", name, n, m_mode, target);
    end
  endtask

  initial begin
    logic [1:0] exp_pops [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
    logic [1:0] exp_path [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
    int bad;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst stk_pop", 32'(stk_pop), 32'(0));
    chk("rst move_valid", 32'(move_valid), 32'(0));
    chk("rst move", 32'(move), 32'(0));
    chk("rst count", 32'(count), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst done", 32'(done), 32'(0));
    chk("rst ovf", 32'(ovf), 32'(0));
    cycle();
    rst = 1'b1;
    cycle();

    // Four-move path: drain order and forward replay
    stk.push_back(2'b11); stk.push_back(2'b00); stk.push_back(2'b01); stk.push_back(2'b10);
    popped.delete();
    load = 1'b1; cycle(); load = 1'b0;
    wait_mode(M_READY, 20, "drain4");
    chk("drain4 pops", 32'(popped.size()), 32'(4));
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("drain4 pop data", 32'(popped[i]), 32'(exp_pops[i]));
    chk("drain4 count", 32'(count), 32'(4));

    for (int r = 0; r < 2; r++) begin
      played.delete(); done_cnt = 0;
      move_ready = 1'b1; run = 1'b1; cycle(); run = 1'b0;
      wait_mode(M_READY, 20, "replay4");
      chk("replay4 len", 32'(played.size()), 32'(4));
      for (int i = 0; i < 4 && i < played.size(); i++) chk("replay4 move", 32'(played[i]), 32'(exp_path[i]));
      chk("replay4 done pulses", 32'(done_cnt), 32'(1));
      chk("replay4 count kept", 32'(count), 32'(4));
    end

    // Backpressure on the second move
    played.delete();
    move_ready = 1'b1; run = 1'b1; cycle(); run = 1'b0;
    cycle();
    move_ready = 1'b0;
    repeat (3) begin
      chk("bp move held", 32'(move), 32'(2'b00));
      chk("bp valid held", 32'(move_valid), 32'(1));
      cycle();
    end
    move_ready = 1'b1;
    wait_mode(M_READY, 20, "bp replay");
    chk("bp len", 32'(played.size()), 32'(4));
    for (int i = 0; i < 4 && i < played.size(); i++) chk("bp move", 32'(played[i]), 32'(exp_path[i]));

    // load and run together in READY: the drain wins
    stk.push_back(2'b01); stk.push_back(2'b10);
    load = 1'b1; run = 1'b1; cycle(); load = 1'b0; run = 1'b0;
    chk("load+run busy", 32'(busy), 32'(1));
    chk("load+run no play", 32'(move_valid), 32'(0));
    wait_mode(M_READY, 20, "load+run");
    chk("load+run count", 32'(count), 32'(2));

    // Empty stack: nothing captured, replay finishes at once
    stk.delete(); popped.delete();
    load = 1'b1; cycle(); load = 1'b0;
    wait_mode(M_READY, 20, "empty drain");
    chk("empty pops", 32'(popped.size()), 32'(0));
    chk("empty count", 32'(count), 32'(0));
    done_cnt = 0; mv_cycles = 0;
    run = 1'b1; cycle(); run = 1'b0;
    chk("empty done next cycle", 32'(done), 32'(1));
    repeat (3) cycle();
    chk("empty done pulses", 32'(done_cnt), 32'(1));
    chk("empty no valid", 32'(mv_cycles), 32'(0));

    // Overflow: 257 moves, only 256 fit
    orig.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      orig.push_back(2'($urandom_range(0, 3)));
      stk.push_back(orig[i]);
    end
    popped.delete();
    load = 1'b1; cycle(); load = 1'b0;
    wait_mode(M_READY, 300, "ovf drain");
    chk("ovf flag", 32'(ovf), 32'(1));
    chk("ovf count", 32'(count), 32'(DEPTH));
    chk("ovf pops", 32'(popped.size()), 32'(DEPTH));
    chk("ovf stack left", 32'(stk.size()), 32'(1));
    played.delete();
    rnd_ready = 1'b1;
    move_ready = 1'b1; run = 1'b1; cycle(); run = 1'b0;
    wait_mode(M_READY, 2000, "ovf replay");
    rnd_ready = 1'b0;
    chk("ovf replay len", 32'(played.size()), 32'(DEPTH));
    bad = 0;
    for (int i = 0; i < DEPTH && i < played.size(); i++) if (played[i] !== orig[i + 1]) bad++;
    chk("ovf replay order errors", 32'(bad), 32'(0));

    // Reset in the third PLAY cycle
    move_ready = 1'b1; run = 1'b1; cycle(); run = 1'b0;
    cycle(); cycle();
    #2 rst = 1'b0;
    #1;
    chk("mid rst stk_pop", 32'(stk_pop), 32'(0));
    chk("mid rst move_valid", 32'(move_valid), 32'(0));
    chk("mid rst move", 32'(move), 32'(0));
    chk("mid rst count", 32'(count), 32'(0));
    chk("mid rst busy", 32'(busy), 32'(0));
    chk("mid rst done", 32'(done), 32'(0));
    chk("mid rst ovf", 32'(ovf), 32'(0));
    model_reset();
    @(negedge clk);
    cycle();
    rst = 1'b1;
    mv_cycles = 0;
    run = 1'b1;
    repeat (4) cycle();
    run = 1'b0;
    chk("post rst run ignored", 32'(mv_cycles), 32'(0));
    stk.delete(); stk.push_back(2'b11);
    load = 1'b1; cycle(); load = 1'b0;
    wait_mode(M_READY, 20, "post rst drain");
    chk("post rst count", 32'(count), 32'(1));

    // Randomised traffic against the model
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) stk.push_back(2'($urandom_range(0, 3)));
      for (int c = 0; c < 60; c++) begin
        load       = ($urandom_range(0, 9) == 0);
        run        = ($urandom_range(0, 3) == 0);
        move_ready = ($urandom_range(0, 2) != 0);
        cycle();
      end
    end
    load = 1'b0; run = 1'b0; move_ready = 1'b1;
    repeat (20) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
